// File: rtl/delay_line_ram_if.sv
// Sample/read-request bundle between the codec path, the delay line and the vibrato stage.
interface delay_line_ram_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 13
);
  logic [DATA_WIDTH-1:0] sample_in;
  logic                  sample_valid;
  logic                  rd;
  logic [ADDR_WIDTH-1:0] offset;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  read_finish;
  logic                  overflow;
  logic [ADDR_WIDTH:0]   fill;

  modport master (
    output sample_in, sample_valid, rd, offset,
    input  data_out, read_finish, overflow, fill
  );

  modport slave (
    input  sample_in, sample_valid, rd, offset,
    output data_out, read_finish, overflow, fill
  );
endinterface

// File: rtl/delay_line_ram.sv
// Circular sample delay line on a single-port RAM; reads address a sample by its age
// behind the newest write. One write slot and one read slot buffer requests while busy.
module delay_line_ram #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 13
) (
  input logic             clk,
  input logic             rst,
  delay_line_ram_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [2:0] {IDLE, WRITE, READ, WAIT, FINISH} state_t;

  state_t                state, state_nxt;
  logic                  wp_full, rp_full;
  logic [DATA_WIDTH-1:0] wp_data;
  logic [ADDR_WIDTH-1:0] rp_off, wr_ptr, rd_addr, ram_addr;
  logic [ADDR_WIDTH:0]   fill_q;
  logic [DATA_WIDTH-1:0] data_q, ram_q;
  logic                  finish_q, ovf_q;
  logic                  rd_busy, rd_take, wr_take, wr_drop;

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

  // The write slot drains during WRITE, so a sample arriving then refills it.
  assign rd_busy = (state == READ) || (state == WAIT) || (state == FINISH);
  assign rd_take = bus.rd && !rp_full && !rd_busy;
  assign wr_take = bus.sample_valid && (!wp_full || (state == WRITE));
  assign wr_drop = bus.sample_valid && !wr_take;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // A read that waited behind a write goes straight to READ after the commit.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (wp_full || bus.sample_valid) state_nxt = WRITE;
        else if (rp_full || rd_take)     state_nxt = READ;
      end
      WRITE:   state_nxt = (rp_full || rd_take) ? READ : IDLE;
      READ:    state_nxt = WAIT;
      WAIT:    state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp_full  <= 1'b0;
      wp_data  <= '0;
      rp_full  <= 1'b0;
      rp_off   <= '0;
      wr_ptr   <= '0;
      rd_addr  <= '0;
      fill_q   <= '0;
      data_q   <= '0;
      finish_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      if (wr_take) begin
        wp_full <= 1'b1;
        wp_data <= bus.sample_in;
      end else if (state == WRITE) begin
        wp_full <= 1'b0;
      end
      if (wr_drop) ovf_q <= 1'b1;

      if (rd_take) begin
        rp_full <= 1'b1;
        rp_off  <= bus.offset;
      end else if (state == READ) begin
        rp_full <= 1'b0;
      end

      if (state == WRITE) begin
        wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
        if (fill_q != FULL) fill_q <= fill_q + (ADDR_WIDTH+1)'(1);
      end

      // wr_ptr - 1 - off == wr_ptr + ~off in ADDR_WIDTH-bit arithmetic
      if (state == READ) rd_addr <= wr_ptr + ~rp_off;

      finish_q <= (state == FINISH);
      if (state == FINISH)
        data_q <= ({1'b0, rp_off} >= fill_q) ? '0 : ram_q;
    end
  end

  // Single-port RAM with registered output; contents survive reset.
  assign ram_addr = (state == WRITE) ? wr_ptr : rd_addr;

  always_ff @(posedge clk) begin
    if (state == WRITE) mem[ram_addr] <= wp_data;
    ram_q <= mem[ram_addr];
  end

  assign bus.data_out    = data_q;
  assign bus.read_finish = finish_q;
  assign bus.overflow    = ovf_q;
  assign bus.fill        = fill_q;

endmodule

// File: tb/tb_delay_line_ram.sv
// Directed bench for delay_line_ram: expected reads are queued when requested and
// matched (data and arrival cycle) when read_finish pulses.
module tb_delay_line_ram;
  localparam int DW = 16;
  localparam int AW = 13;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #10 clk = ~clk;

  delay_line_ram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  delay_line_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every read_finish must match the oldest queued request.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst && bus.read_finish) begin
      check("rf_expected", 32'(bus.read_finish), 32'(sb.size() != 0));
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("rd_data", 32'(bus.data_out), 32'(e.data));
        check("rd_latency", 32'(cyc), 32'(e.due));
      end
    end
  end

  task automatic write_sample(input logic [DW-1:0] v, input int gap);
    bus.sample_in    = v;
    bus.sample_valid = 1'b1;
    @(negedge clk);
    bus.sample_valid = 1'b0;
    repeat (gap - 1) @(negedge clk);
  endtask

  task automatic post_read(input logic [AW-1:0] off, input logic [DW-1:0] d, input int lat);
    sb.push_back('{data: d, due: cyc + 1 + lat});
    bus.offset = off;
    bus.rd     = 1'b1;
    @(negedge clk);
    bus.rd     = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  initial begin
    bus.sample_in    = '0;
    bus.sample_valid = 1'b0;
    bus.rd           = 1'b0;
    bus.offset       = '0;
    repeat (3) @(negedge clk);
    check("rst_data_out", 32'(bus.data_out), 32'd0);
    check("rst_read_finish", 32'(bus.read_finish), 32'd0);
    check("rst_overflow", 32'(bus.overflow), 32'd0);
    check("rst_fill", 32'(bus.fill), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // newest and older sample
    write_sample(16'd5, 4);
    write_sample(16'd6, 4);
    write_sample(16'd7, 4);
    check("fill_3", 32'(bus.fill), 32'd3);
    post_read(13'd0, 16'd7, 3);
    drain("drain_off0");
    post_read(13'd2, 16'd5, 3);
    drain("drain_off2");

    // offset beyond written history reads as zero
    post_read(13'd3, 16'd0, 3);
    drain("drain_unwritten");
    check("fill_still_3", 32'(bus.fill), 32'd3);

    // same-edge write and read: write commits first
    sb.push_back('{data: 16'h1234, due: cyc + 1 + 4});
    bus.sample_in    = 16'h1234;
    bus.sample_valid = 1'b1;
    bus.offset       = '0;
    bus.rd           = 1'b1;
    @(negedge clk);
    bus.sample_valid = 1'b0;
    bus.rd           = 1'b0;
    drain("drain_same_edge");
    repeat (2) @(negedge clk);
    check("fill_4", 32'(bus.fill), 32'd4);
    check("no_overflow_yet", 32'(bus.overflow), 32'd0);

    // three back-to-back samples around a read: A written, B held, C lost
    sb.push_back('{data: 16'h0AAA, due: cyc + 1 + 4});
    bus.sample_in    = 16'h0AAA;
    bus.sample_valid = 1'b1;
    bus.offset       = '0;
    bus.rd           = 1'b1;
    @(negedge clk);
    bus.rd        = 1'b0;
    bus.sample_in = 16'h0BBB;
    @(negedge clk);
    bus.sample_in = 16'h0CCC;
    @(negedge clk);
    bus.sample_valid = 1'b0;
    drain("drain_burst");
    repeat (3) @(negedge clk);
    check("overflow_set", 32'(bus.overflow), 32'd1);
    check("fill_6", 32'(bus.fill), 32'd6);
    post_read(13'd0, 16'h0BBB, 3);
    drain("drain_b");
    post_read(13'd1, 16'h0AAA, 3);
    drain("drain_a");
    repeat (3) @(negedge clk);
    check("data_out_hold", 32'(bus.data_out), 32'h0AAA);

    // reset while the read sits in WAIT: aborted, everything cleared
    bus.offset = '0;
    bus.rd     = 1'b1;
    @(negedge clk);
    bus.rd = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_data_out", 32'(bus.data_out), 32'd0);
    check("abort_read_finish", 32'(bus.read_finish), 32'd0);
    check("abort_overflow", 32'(bus.overflow), 32'd0);
    check("abort_fill", 32'(bus.fill), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);

    // fill past DEPTH to exercise saturation and pointer wrap
    for (int i = 0; i < DEPTH + 2; i++) write_sample(DW'(i), 2);
    repeat (2) @(negedge clk);
    check("fill_sat", 32'(bus.fill), 32'(DEPTH));
    check("wrap_no_overflow", 32'(bus.overflow), 32'd0);
    post_read(13'd0, DW'(DEPTH + 1), 3);
    drain("drain_wrap_newest");
    post_read(AW'(DEPTH - 1), 16'd2, 3);
    drain("drain_wrap_oldest");

    repeat (4) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end
endmodule
